// File: rtl/btn_debounce_pulse.sv
// Pushbutton cleaner: 2-FF synchronizer, stability filter and press FSM.
// Optional long-press pulse is built only when LONG_PRESS_EN is defined.
module btn_debounce_pulse #(
   parameter int unsigned STABLE_CYCLES = 1_000_000,
   parameter int unsigned CNT_W         = 20,
   parameter int unsigned HOLD_CYCLES   = 200_000_000,
   parameter int unsigned HOLD_W        = 28
) (
   input  logic clock,
   input  logic resett,
   input  logic btn,
   output logic btn_level,
   output logic press_pulse,
   output logic long_pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   // Reject parameter sets the counters cannot represent.
   if (STABLE_CYCLES < 2 ||
       (64'(1) << CNT_W) <= 64'(STABLE_CYCLES) ||
       HOLD_CYCLES < 1 ||
       (64'(1) << HOLD_W) <= 64'(HOLD_CYCLES)) begin : g_bad_params
      $error("btn_debounce_pulse: illegal parameters");
   end

   typedef enum logic [1:0] {
      IDLE,
      ARM_PRESS,
      PRESSED,
      ARM_RELEASE
   } state_t;

   state_t           state_q, state_d;
   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             enter_pressed;

   // Synchronizer chain; only s2 feeds the filter.
   always_comb begin
      s1_d = btn;
      s2_d = s1_q;
   end

   // Stability filter and press FSM next-state logic.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      level_d       = level_q;
      press_d       = 1'b0;
      enter_pressed = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (s2_q) begin
               state_d = ARM_PRESS;
               cnt_d   = '0;
            end
         end
         ARM_PRESS: begin
            if (!s2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d       = PRESSED;
               level_d       = 1'b1;
               press_d       = 1'b1;
               cnt_d         = '0;
               enter_pressed = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!s2_q) begin
               state_d = ARM_RELEASE;
               cnt_d   = '0;
            end
         end
         ARM_RELEASE: begin
            if (s2_q) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               level_d = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Filter, FSM and output registers.
   always_ff @(posedge clock) begin
      if (resett) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign btn_level   = level_q;
   assign press_pulse = press_q;

`ifdef LONG_PRESS_EN
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_CYCLES);

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              long_q, long_d;

   // Hold timer: restarts on a new press, survives release glitches,
   // fires once at the threshold and then parks past it.
   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (enter_pressed) begin
         hold_d = '0;
      end else if (level_q) begin
         if (hold_q == HOLD_LAST) begin
            long_d = 1'b1;
            hold_d = HOLD_SAT;
         end else if (hold_q != HOLD_SAT) begin
            hold_d = hold_q + 1'b1;
         end
      end else begin
         hold_d = '0;
      end
   end

   // Hold timer registers.
   always_ff @(posedge clock) begin
      if (resett) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_pulse = long_q;
`else
   assign long_pulse = 1'b0;
`endif

endmodule
